host_spi_slave: RTL and testbench

HOST_SPI_SLAVE -- requirements
Module: host_spi_slave

---
 rtl/host_spi_slave_pkg.sv | 15 +
 rtl/host_spi_slave_if.sv | 41 ++++
 rtl/host_spi_slave_byte_fifo.sv | 82 ++++++++
 rtl/host_spi_slave.sv | 164 ++++++++++++++++
 tb/tb_host_spi_slave.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/host_spi_slave_pkg.sv
// host_spi_slave_pkg
// Shared definitions for the SPI slave block: the frame state machine
// encoding, the depth of the input synchronizers and the default byte
// driven on MISO when the transmit FIFO has nothing to offer.
package host_spi_slave_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   localparam int         SYNC_STAGES       = 2;
   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/host_spi_slave_if.sv
// host_spi_slave_if
// Bundles the SPI pins, the receive FIFO consumer port, the upstream
// transmit FIFO port and the overflow flag of host_spi_slave.
//   slave  : view used by host_spi_slave
//   master : view used by whatever drives the SPI pins and the FIFOs
interface host_spi_slave_if #(
   parameter int RX_DEPTH = 8
);
   import host_spi_slave_pkg::*;

   localparam int LVL_W = $clog2(RX_DEPTH) + 1;

   logic             spi_cs_n;
   logic             spi_sclk;
   logic             spi_mosi;
   logic             spi_miso;
   logic             rx_fifo_rd_en;
   logic [7:0]       rx_fifo_din;
   logic             rx_fifo_empty;
   logic [LVL_W-1:0] rx_level;
   logic             tx_fifo_rd_en;
   logic [7:0]       tx_fifo_dout;
   logic             tx_fifo_empty;
   logic             rx_ovf_clr;
   logic             rx_overflow;

   modport slave (
      input  spi_cs_n, spi_sclk, spi_mosi, rx_fifo_rd_en,
             tx_fifo_dout, tx_fifo_empty, rx_ovf_clr,
      output spi_miso, rx_fifo_din, rx_fifo_empty, rx_level,
             tx_fifo_rd_en, rx_overflow
   );

   modport master (
      output spi_cs_n, spi_sclk, spi_mosi, rx_fifo_rd_en,
             tx_fifo_dout, tx_fifo_empty, rx_ovf_clr,
      input  spi_miso, rx_fifo_din, rx_fifo_empty, rx_level,
             tx_fifo_rd_en, rx_overflow
   );

endinterface

// File: rtl/host_spi_slave_byte_fifo.sv
// host_byte_fifo
// Byte FIFO with first-word fall-through head, used as the SPI receive queue.
//   clk, reset : system clock, synchronous active-high reset
//   push, din  : write strobe and byte; ignored when full unless popping
//   pop        : read strobe; ignored when empty
//   dout       : head byte (0 while empty)
//   empty/full : occupancy flags, level : number of stored bytes
module host_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             AW      = $clog2(DEPTH);
   localparam int             LW      = AW + 1;
   localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0]  LVL_ONE = LW'(1);
   localparam logic [AW-1:0]  PTR_ONE = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          pop_ok_s;
   logic          push_ok_s;

   // Accept/reject decisions, next pointers, level and storage update.
   always_comb begin
      empty     = (level_q == {LW{1'b0}});
      full      = (level_q == DEPTH_L);
      pop_ok_s  = pop & ~empty;
      // A pop in the same cycle frees the slot a full FIFO needs.
      push_ok_s = push & (~full | pop_ok_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      dout  = empty ? 8'h00 : mem_q[rd_ptr_q];
      level = level_q;
   end

   // Storage and pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: 8'h00};
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/host_spi_slave.sv
// host_spi_slave
// SPI mode-0 slave clocked entirely by the system clock. CS, SCLK and MOSI
// are synchronized and edge-detected, so f_clk must be at least 8x f_sclk.
// Received bytes go into a byte FIFO; transmit bytes are pulled from an
// upstream FIFO at frame start and after every completed byte.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : SPI pins, rx FIFO consumer port, tx FIFO port, overflow flag
module host_spi_slave
   import host_spi_slave_pkg::*;
#(
   parameter int         RX_DEPTH  = 8,
   parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   host_spi_slave_if.slave bus
);

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sclk_prev_q, sclk_prev_d;
   spi_state_e             state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             rx_shift_q, rx_shift_d;
   logic [7:0]             tx_shift_q, tx_shift_d;
   logic                   miso_q, miso_d;
   logic                   tx_rd_en_q, tx_rd_en_d;
   logic                   ovf_q, ovf_d;

   logic       cs_s, sclk_s, mosi_s;
   logic       cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
   logic       load_s, push_s, drop_s;
   logic [7:0] push_byte_s, tx_next_s;
   logic       fifo_empty_s, fifo_full_s;

   // Synchronizer shifting and edge detection on the synchronized copies.
   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_s        = cs_sync_q[SYNC_STAGES-1];
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      cs_prev_d   = cs_s;
      sclk_prev_d = sclk_s;
      cs_fall_s   = cs_prev_q & ~cs_s;
      cs_rise_s   = ~cs_prev_q & cs_s;
      sclk_rise_s = ~sclk_prev_q & sclk_s;
      sclk_fall_s = sclk_prev_q & ~sclk_s;
   end

   // Frame state machine, shifters and output next-state.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      load_s      = 1'b0;
      push_s      = 1'b0;
      push_byte_s = {rx_shift_q[6:0], mosi_s};
      tx_next_s   = bus.tx_fifo_empty ? IDLE_BYTE : bus.tx_fifo_dout;
      case (state_q)
         IDLE: begin
            if (cs_fall_s) begin
               state_d    = ACTIVE;
               bit_cnt_d  = 3'd0;
               load_s     = 1'b1;
               tx_shift_d = tx_next_s;
            end else begin
               state_d    = IDLE;
            end
         end
         ACTIVE: begin
            // CS release wins over any SCLK edge: partial rx bits are dropped.
            if (cs_rise_s) begin
               state_d   = IDLE;
               bit_cnt_d = 3'd0;
            end else if (sclk_rise_s) begin
               rx_shift_d = push_byte_s;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               push_s     = (bit_cnt_q == 3'd7);
            end else if (sclk_fall_s) begin
               // Counter at 0 here means a byte just completed.
               if (bit_cnt_q == 3'd0) begin
                  load_s     = 1'b1;
                  tx_shift_d = tx_next_s;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
         end
      endcase
      // The upstream pop trails the load by one cycle; its head stays valid until then.
      tx_rd_en_d = load_s & ~bus.tx_fifo_empty;
      miso_d     = (state_d == ACTIVE) ? tx_shift_d[7] : 1'b0;
      drop_s     = push_s & fifo_full_s & ~(bus.rx_fifo_rd_en & ~fifo_empty_s);
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (bus.rx_ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Block state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_sync_q <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         miso_q      <= 1'b0;
         tx_rd_en_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_prev_q   <= cs_prev_d;
         sclk_prev_q <= sclk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         tx_rd_en_q  <= tx_rd_en_d;
         ovf_q       <= ovf_d;
      end
   end

   host_byte_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .din   (push_byte_s),
      .pop   (bus.rx_fifo_rd_en),
      .dout  (bus.rx_fifo_din),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .level (bus.rx_level)
   );

   assign bus.rx_fifo_empty = fifo_empty_s;
   assign bus.spi_miso      = miso_q;
   assign bus.tx_fifo_rd_en = tx_rd_en_q;
   assign bus.rx_overflow   = ovf_q;

endmodule

// File: tb/tb_host_spi_slave.sv
// tb_host_spi_slave
// Directed bench for host_spi_slave: drives SPI mode-0 frames at a slow
// SCLK, models the upstream transmit FIFO as a queue, and compares outputs
// against hand-computed values through check_val.
module tb_host_spi_slave;
   import host_spi_slave_pkg::*;

   localparam int RX_DEPTH = 8;
   localparam int HALF     = 8;   // system clocks per SCLK half period

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   rd_pulses = 0;
   logic [7:0] tx_q [$];
   logic [7:0] seq3 [3] = '{8'h01, 8'h80, 8'hFF};

   always #5 clk = ~clk;

   host_spi_slave_if #(.RX_DEPTH(RX_DEPTH)) bus ();

   host_spi_slave #(
      .RX_DEPTH  (RX_DEPTH),
      .IDLE_BYTE (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Upstream tx FIFO: pops on the strobe, presents its head on the falling edge.
   always @(posedge clk) begin
      if (bus.tx_fifo_rd_en === 1'b1) begin
         rd_pulses = rd_pulses + 1;
         if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
   end

   always @(negedge clk) begin
      bus.tx_fifo_empty = (tx_q.size() == 0);
      bus.tx_fifo_dout  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      bus.spi_cs_n = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic cs_high();
      wait_clks(HALF);
      bus.spi_cs_n = 1'b1;
      wait_clks(HALF);
   endtask

   // Send nbits of tx_b MSB-first; rx_b collects MISO sampled before each rise.
   // pop_last raises rx_fifo_rd_en exactly in the cycle the final rise pushes.
   task automatic spi_bits(input logic [7:0] tx_b, input int nbits, input bit pop_last,
                           output logic [7:0] rx_b);
      rx_b = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.spi_mosi = tx_b[7-i];
         wait_clks(HALF);
         rx_b = {rx_b[6:0], bus.spi_miso};
         bus.spi_sclk = 1'b1;
         if (pop_last && (i == nbits - 1)) begin
            wait_clks(2);
            bus.rx_fifo_rd_en = 1'b1;
            wait_clks(1);
            bus.rx_fifo_rd_en = 1'b0;
            wait_clks(HALF - 3);
         end else begin
            wait_clks(HALF);
         end
         bus.spi_sclk = 1'b0;
      end
   endtask

   task automatic pop_byte();
      bus.rx_fifo_rd_en = 1'b1;
      wait_clks(1);
      bus.rx_fifo_rd_en = 1'b0;
      wait_clks(1);
   endtask

   initial begin
      logic [7:0] m;
      logic [7:0] b;
      int         p0;

      reset             = 1'b1;
      bus.spi_cs_n      = 1'b0;
      bus.spi_sclk      = 1'b0;
      bus.spi_mosi      = 1'b0;
      bus.rx_fifo_rd_en = 1'b0;
      bus.rx_ovf_clr    = 1'b0;

      // Reset held 3 cycles with CS low.
      wait_clks(3);
      check_val("rst_miso",     bus.spi_miso,      1'b0);
      check_val("rst_empty",    bus.rx_fifo_empty, 1'b1);
      check_val("rst_level",    bus.rx_level,      4'd0);
      check_val("rst_din",      bus.rx_fifo_din,   8'h00);
      check_val("rst_tx_rd_en", bus.tx_fifo_rd_en, 1'b0);
      check_val("rst_ovf",      bus.rx_overflow,   1'b0);
      reset        = 1'b0;
      bus.spi_cs_n = 1'b1;
      wait_clks(10);
      check_val("rst_no_pop", rd_pulses, 0);

      // Single frame: tx 0xA5, rx 0x3C.
      tx_q.push_back(8'hA5);
      wait_clks(2);
      p0 = rd_pulses;
      cs_low();
      spi_bits(8'h3C, 8, 1'b0, m);
      cs_high();
      check_val("single_miso",  m, 8'hA5);
      check_val("single_pops",  rd_pulses - p0, 1);
      check_val("single_din",   bus.rx_fifo_din, 8'h3C);
      check_val("single_level", bus.rx_level, 4'd1);
      check_val("single_empty", bus.rx_fifo_empty, 1'b0);
      check_val("idle_miso",    bus.spi_miso, 1'b0);
      pop_byte();
      check_val("single_drain", bus.rx_fifo_empty, 1'b1);

      // Back-to-back bytes under one CS, tx FIFO empty.
      cs_low();
      for (int i = 0; i < 3; i++) begin
         spi_bits(seq3[i], 8, 1'b0, m);
         check_val("b2b_miso", m, 8'h00);
      end
      cs_high();
      check_val("b2b_level", bus.rx_level, 4'd3);
      for (int i = 0; i < 3; i++) begin
         check_val("b2b_din", bus.rx_fifo_din, seq3[i]);
         pop_byte();
      end
      check_val("b2b_empty", bus.rx_fifo_empty, 1'b1);

      // Overflow: nine bytes, no pops.
      cs_low();
      for (int i = 0; i < 9; i++) begin
         b = 8'h10 + 8'(i);
         spi_bits(b, 8, 1'b0, m);
      end
      cs_high();
      check_val("ovf_level", bus.rx_level, 4'd8);
      check_val("ovf_flag",  bus.rx_overflow, 1'b1);
      check_val("ovf_head",  bus.rx_fifo_din, 8'h10);
      bus.rx_ovf_clr = 1'b1;
      wait_clks(1);
      bus.rx_ovf_clr = 1'b0;
      wait_clks(1);
      check_val("ovf_clr", bus.rx_overflow, 1'b0);

      // Full FIFO: push coincides with pop.
      cs_low();
      spi_bits(8'h99, 8, 1'b1, m);
      cs_high();
      check_val("fullpop_level", bus.rx_level, 4'd8);
      check_val("fullpop_ovf",   bus.rx_overflow, 1'b0);
      for (int i = 0; i < 7; i++) begin
         b = 8'h11 + 8'(i);
         check_val("fullpop_din", bus.rx_fifo_din, b);
         pop_byte();
      end
      check_val("fullpop_last", bus.rx_fifo_din, 8'h99);
      pop_byte();
      check_val("fullpop_empty", bus.rx_fifo_empty, 1'b1);

      // Abort after 5 bits, then a full frame.
      tx_q.push_back(8'hC3);
      wait_clks(2);
      p0 = rd_pulses;
      cs_low();
      spi_bits(8'hF0, 5, 1'b0, m);
      cs_high();
      check_val("abort_level",   bus.rx_level, 4'd0);
      check_val("abort_empty",   bus.rx_fifo_empty, 1'b1);
      check_val("abort_pops",    rd_pulses - p0, 1);
      check_val("abort_miso",    m, 8'h18);
      check_val("abort_idle",    bus.spi_miso, 1'b0);
      cs_low();
      spi_bits(8'h55, 8, 1'b0, m);
      cs_high();
      check_val("after_din",   bus.rx_fifo_din, 8'h55);
      check_val("after_level", bus.rx_level, 4'd1);
      check_val("after_miso",  m, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
